// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - opcode constants, FSM states and helpers shared by the ALU issue controller
package alu_issue_ctrl_pkg;

    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
    localparam logic [3:0] OP_NOP = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_SLL = 4'd10;
    localparam logic [3:0] OP_SRL = 4'd11;
    localparam logic [3:0] OP_OR  = 4'd12;
    localparam logic [3:0] OP_AND = 4'd13;
    localparam logic [3:0] OP_SUB = 4'd14;
    localparam logic [3:0] OP_ADD = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// rtl/alu_issue_ctrl_rr_arb2.sv - two-input combinational round-robin grant
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant0,
    output logic grant1
);

    // On contention the port not served last wins; a lone requester always wins.
    assign grant0 = valid0 && (!valid1 || last_grant);
    assign grant1 = valid1 && (!valid0 || !last_grant);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - shares one ALU between two requesters and registers its response
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_remainder,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_overflow,
    output logic             busy
);

    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

    state_t     state;
    logic       last_grant;
    logic       cur_id;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic [3:0] sel_op;
    logic       div_zero;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    assign req0_ready = (state == ST_IDLE) && grant0;
    assign req1_ready = (state == ST_IDLE) && grant1;
    assign rsp_valid  = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);
    assign sel_op     = grant1 ? req1_op : req0_op;
    assign div_zero   = (alu_ctrl == OP_DIV) && (alu_b == '0);

    // The alu_* outputs double as the latched operation, so they stay stable through EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            alu_ctrl      <= OP_NOP;
            alu_a         <= '0;
            alu_b         <= '0;
            cur_id        <= 1'b0;
            cnt           <= 4'd0;
            last_grant    <= 1'b1;
            rsp_id        <= 1'b0;
            rsp_result    <= '0;
            rsp_remainder <= '0;
            rsp_overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        alu_ctrl <= sel_op;
                        alu_a    <= grant1 ? req1_a : req0_a;
                        alu_b    <= grant1 ? req1_b : req0_b;
                        cur_id   <= grant1;
                        cnt      <= is_muldiv(sel_op) ? MD_LOAD : 4'd0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (div_zero) begin
                            rsp_result    <= '1;
                            rsp_remainder <= alu_a;
                            rsp_overflow  <= 1'b1;
                        end else begin
                            rsp_result    <= alu_result;
                            rsp_remainder <= alu_remainder;
                            rsp_overflow  <= alu_overflow;
                        end
                        rsp_id     <= cur_id;
                        last_grant <= cur_id;
                        alu_ctrl   <= OP_NOP;
                        alu_a      <= '0;
                        alu_b      <= '0;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - randomized and directed bench for alu_issue_ctrl against a transaction model
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int W   = 16;
    localparam int MDC = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = 0, req1_op = 0;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] alu_a, alu_b, alu_result, alu_remainder;
    logic         alu_overflow;
    logic         rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_overflow, busy;
    logic [W-1:0] rsp_result, rsp_remainder;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    alu_issue_ctrl #(.WIDTH(W), .MULDIV_CYCLES(MDC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_remainder(alu_remainder), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_remainder(rsp_remainder), .rsp_overflow(rsp_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stand-in ALU: {overflow, remainder, result}. Div-by-zero returns junk the controller must ignore.
    function automatic logic [32:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        logic [16:0] s;
        case (op)
            4'd1: begin p = 32'(a) * 32'(b); return {p[31:16] != 16'd0, p[31:16], p[15:0]}; end
            4'd2: if (b != 16'd0) return {1'b0, a % b, a / b};
                  else return {1'b0, 16'h5678, 16'h1234};
            4'd14: begin s = 17'(a) - 17'(b); return {s[16], 16'h0, s[15:0]}; end
            4'd15: begin s = 17'(a) + 17'(b); return {s[16], 16'h0, s[15:0]}; end
            default: return {op[0], 16'h0, a ^ b ^ {12'h0, op}};
        endcase
    endfunction

    function automatic logic [32:0] exp_rsp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        if (op == 4'd2 && b == 16'd0) return {1'b1, a, 16'hFFFF};
        return alu_fn(op, a, b);
    endfunction

    always_comb {alu_overflow, alu_remainder, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: one outstanding op, the cycle its response should appear, and the fairness pointer.
    bit          m_active = 0;
    bit          m_last = 1;
    bit          m_id;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b;
    int          m_rsp_from;
    bit          e0, e1;
    logic [32:0] m_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0;
            m_last   = 1;
            chk("rst_busy", 32'(busy), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_alu_ctrl", 32'(alu_ctrl), 6);
            chk("rst_alu_ab", {alu_a, alu_b}, 0);
            chk("rst_rsp_data", {rsp_result, rsp_remainder}, 0);
            chk("rst_rsp_flags", {30'd0, rsp_id, rsp_overflow}, 0);
        end else begin
            chk("never_both_ready", 32'(req0_ready & req1_ready), 0);
            chk("busy", 32'(busy), 32'(m_active));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_active && cyc >= m_rsp_from));
            if (!m_active) begin
                e0 = req0_valid && (!req1_valid || m_last);
                e1 = req1_valid && (!req0_valid || !m_last);
                chk("req0_ready", 32'(req0_ready), 32'(e0));
                chk("req1_ready", 32'(req1_ready), 32'(e1));
                chk("idle_alu", {12'd0, alu_ctrl, alu_a}, {12'd0, 4'd6, 16'd0});
                chk("idle_alu_b", 32'(alu_b), 0);
                if (e0 || e1) begin
                    m_active   = 1;
                    m_id       = e1;
                    m_op       = e1 ? req1_op : req0_op;
                    m_a        = e1 ? req1_a : req0_a;
                    m_b        = e1 ? req1_b : req0_b;
                    m_rsp_from = cyc + 1 + ((m_op == 4'd1 || m_op == 4'd2) ? MDC : 1);
                end
            end else if (cyc < m_rsp_from) begin
                chk("exec_no_ready", {req0_ready, req1_ready}, 0);
                chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(m_op));
                chk("exec_alu_ab", {alu_a, alu_b}, {m_a, m_b});
            end else begin
                m_r = exp_rsp(m_op, m_a, m_b);
                chk("resp_no_ready", {req0_ready, req1_ready}, 0);
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_result", 32'(rsp_result), 32'(m_r[15:0]));
                chk("rsp_remainder", 32'(rsp_remainder), 32'(m_r[31:16]));
                chk("rsp_overflow", 32'(rsp_overflow), 32'(m_r[32]));
                if (rsp_ready) begin
                    m_active = 0;
                    m_last   = m_id;
                end
            end
        end
    end

    // Issue one request and wait for its response; lat counts cycles from the ready cycle to rsp_valid.
    task automatic do_req(input bit port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, output int lat, output logic [33:0] got);
        int t0;
        bit seen;
        @(posedge clk); #1;
        if (port) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else      begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        rsp_ready = (hold == 0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = port ? req1_ready : req0_ready;
        end
        if (!seen) chk("accept_timeout", 0, 1);
        t0 = cyc;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        if (!seen) chk("rsp_timeout", 0, 1);
        lat = cyc - t0;
        got = {rsp_id, rsp_overflow, rsp_remainder, rsp_result};
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            req0_valid = 1; req1_valid = 1;
            @(negedge clk);
            chk("hold_result", 32'(rsp_result), 32'(got[15:0]));
            chk("hold_busy_valid", {busy, rsp_valid}, 2'b11);
            chk("hold_no_ready", {req0_ready, req1_ready}, 0);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        @(negedge clk);
    endtask

    int          lat;
    logic [33:0] got;
    int          grants[$];
    bit          seen_idle;
    int          sel;

    initial begin
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1;

        // Contention from reset: grants must alternate starting at req0.
        req0_valid = 1; req1_valid = 1; req0_op = 15; req1_op = 15;
        req0_a = 1; req0_b = 2; req1_a = 3; req1_b = 4;
        for (int k = 0; k < 40 && grants.size() < 4; k++) begin
            @(negedge clk);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("grant_count", 32'(grants.size()), 4);
        for (int i = 0; i < grants.size() && i < 4; i++) chk("grant_order", 32'(grants[i]), 32'(i % 2));
        seen_idle = 0;
        for (int k = 0; k < 20 && !seen_idle; k++) begin @(negedge clk); seen_idle = !busy; end
        chk("drain_idle", 32'(seen_idle), 1);

        do_req(0, 4'd15, 16'd1000, 16'd50, 0, lat, got);
        chk("add_lat", 32'(lat), 2);
        chk("add_rsp", {14'd0, got[33], got[32], got[15:0]}, {14'd0, 1'b0, 1'b0, 16'd1050});

        do_req(1, 4'd1, 16'd1000, 16'd50, 0, lat, got);
        chk("mul_lat", 32'(lat), 5);
        chk("mul_rsp", {15'd0, got[33], got[15:0]}, {15'd0, 1'b1, 16'hC350});

        do_req(0, 4'd2, 16'd1000, 16'd0, 0, lat, got);
        chk("div0_lat", 32'(lat), 5);
        chk("div0_rsp", got[31:0], {16'd1000, 16'hFFFF});
        chk("div0_ovf", 32'(got[32]), 1);

        do_req(1, 4'd2, 16'd1000, 16'd50, 0, lat, got);
        chk("div_rsp", {15'd0, got[32], got[31:16]}, {15'd0, 1'b0, 16'd0});
        chk("div_quot", 32'(got[15:0]), 20);

        do_req(0, 4'd14, 16'd1000, 16'd50, 5, lat, got);
        chk("sub_rsp", 32'(got[15:0]), 950);

        // Reset in the middle of a MUL: everything clears at once and no response follows.
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 4'd1; req0_a = 16'd7; req0_b = 16'd9;
        @(negedge clk);
        chk("mul_rst_accept", 32'(req0_ready), 1);
        @(posedge clk); #1;
        req0_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("async_rst", {busy, rsp_valid, alu_ctrl}, {1'b0, 1'b0, 4'd6});
        @(posedge clk); #1;
        rst_n = 1;
        repeat (10) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 32'(rsp_valid), 0);
        end

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 7);
            req0_op = (sel < 2) ? 4'd1 : (sel < 4) ? 4'd2 : (sel == 4) ? 4'd14 : 4'($urandom);
            sel = $urandom_range(0, 7);
            req1_op = (sel < 2) ? 4'd2 : (sel < 4) ? 4'd15 : (sel == 4) ? 4'd1 : 4'($urandom);
            req0_a = 16'($urandom); req1_a = 16'($urandom);
            req0_b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
            req1_b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        repeat (20) @(negedge clk);
        chk("final_idle", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Controller that shares the 16-bit `alu` datapath between two requesters. Arbitrates round-robin between two valid/ready request ports, drives `alu` CTRL/operand inputs, holds them stable for single-cycle or multi-cycle (MUL/DIV) operations, and captures result, remainder and overflow into a registered response port. Sits between the issue/decode stage and the `alu` instance in EX.

## Interface
- `WIDTH`, 16: operand/result width.
- `MULDIV_CYCLES`, 4: cycles ALU inputs are held for op 1 (MUL) / op 2 (DIV) before capture; legal range 1–15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`, `req1_valid`  in  1  request valid.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (combinational).
- `req0_op`, `req1_op`  in  4  ALU CTRL code.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands (top/bottom).
- `alu_ctrl`  out  4  to `alu` CTRL.
- `alu_a`, `alu_b`  out  WIDTH  to `alu` MUX_intop/MUX_inbottom.
- `alu_result`, `alu_remainder`  in  WIDTH  from `alu`.
- `alu_overflow`  in  1  from `alu`.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester index of response.
- `rsp_result`, `rsp_remainder`  out  WIDTH  captured results.
- `rsp_overflow`  out  1  captured overflow.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `alu_ctrl`=6 (NOP), `alu_a`=`alu_b`=0. If any `reqN_valid`, grant one: if both valid, grant the port not granted last (`last_grant`, reset = 1, so req0 wins first). Granted `reqN_ready`=1 this cycle only; latch op, a, b, id; load `cnt` = MULDIV_CYCLES−1 for op 1/2, else 0; go EXEC.
- `reqN_ready` is 0 in EXEC and RESP; never both high.
- EXEC: drive `alu_ctrl`/`alu_a`/`alu_b` from latched regs, stable for the whole state. If `cnt`≠0, decrement. If `cnt`=0, capture `alu_result`, `alu_remainder`, `alu_overflow` into rsp regs, update `last_grant`=id, go RESP.
- DIV by zero (op 2, b=0): ALU bypassed; capture result=all-ones, remainder=a, overflow=1 after the normal MULDIV_CYCLES hold.
- All other codes (0,3,4,5,7, and 8–15) are single-cycle; unlisted codes are forwarded unmodified and whatever the ALU returns is captured.
- RESP: `rsp_valid`=1, rsp outputs stable until `rsp_valid && rsp_ready`; then go IDLE. No new request is accepted in the handshake cycle.
- Operands pass straight through; no width conversion; overflow taken only from ALU (except the div-by-zero case).

## Timing
- Reset (async assert, sync release): state IDLE, `alu_ctrl`=6, `alu_a`/`alu_b`=0, all rsp outputs 0, `rsp_valid`=0, `busy`=0, `last_grant`=1, `cnt`=0.
- Accept at edge T (ready high in cycle before T). Single-cycle op: EXEC during cycle T..T+1, `rsp_valid` high from edge T+1. MUL/DIV: `rsp_valid` high from edge T+MULDIV_CYCLES.
- Minimum request-to-request throughput: 3 cycles (IDLE, EXEC, RESP) with `rsp_ready` held high.
- Reset mid-operation: in-flight op and pending response dropped; no response emitted after release.
- Requester dropping valid while not granted: allowed, no effect.

## Structure
- Shared header `alu_defs.vh`: opcode constants OP_MUL=1, OP_DIV=2, OP_NOP=6, OP_ROL=8, OP_ROR=9, OP_SLL=10, OP_SRL=11, OP_OR=12, OP_AND=13, OP_SUB=14, OP_ADD=15; FSM state encodings. Reused by `alu` and decode.
- Sub-module `rr_arb2`: two-input round-robin grant from valids and `last_grant`, purely combinational.

## Test plan
- req0 ADD(15) a=1000 b=50, rsp_ready=1 → rsp_valid 2 edges after accept, result=1050, id=0, overflow=0.
- req1 MUL(1) a=1000 b=50, MULDIV_CYCLES=4 → alu_ctrl=1 held 4 cycles, result=50000 (0xC350), rsp_valid at T+4.
- Both valid every cycle: grants alternate 0,1,0,1; first grant to req0; never both ready.
- DIV(2) a=1000 b=0 → result=0xFFFF, remainder=1000, overflow=1; DIV a=1000 b=50 → result=20, remainder=0.
- rsp_ready low 5 cycles after SUB(14) 1000−50 → rsp outputs stable at 950, busy=1, no ready to either requester; completes on rsp_ready.
- rst_n asserted during MUL EXEC → immediately alu_ctrl=6, busy=0, rsp_valid=0; no response after release.
